md_unit_param: RTL and testbench

//   Parametrised multiply/divide unit with HI/LO registers for the MIPS pipeline EX stage.

---
 rtl/md_unit_param.sv | 137 +++++++++++++
 tb/tb_md_unit_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO registers and mthi/mtlo writes for the EX stage.
// Build option: define MD_UNIT_MACC_EN to enable MADD/MADDU/MSUB/MSUBU (md_op 4-7).
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, hi_reg, lo_reg;
  logic [2:0]         op_reg;
  logic               done_reg;

  logic               op_div, op_ok, accept, commit, mt_ok;
  logic [2*WIDTH-1:0] prod_u, prod_s, acc, res;
  logic [WIDTH-1:0]   mag_a, mag_b, mag_b_safe, b_safe;
  logic [WIDTH-1:0]   sq, sr, quo_s, rem_s, uq, ur;
  logic               sign_a, sign_b;

  assign op_div = (md_op[2:1] == 2'b01);
`ifdef MD_UNIT_MACC_EN
  assign op_ok  = 1'b1;
`else
  assign op_ok  = !md_op[2];
`endif
  assign accept = (state_reg == IDLE) && start && !req && op_ok;
  assign commit = (state_reg != IDLE) && (cnt_reg == CW'(1));
  // A start request in IDLE suppresses mthi/mtlo even when the op itself is rejected.
  assign mt_ok  = (state_reg == IDLE) && !req && !start;

  // Arithmetic works only on the operands latched at launch.
  assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
  assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
  assign acc    = {hi_reg, lo_reg};

  // Signed divide via magnitudes so MIN/-1 wraps to MIN with zero remainder.
  assign sign_a     = a_reg[WIDTH-1];
  assign sign_b     = b_reg[WIDTH-1];
  assign mag_a      = sign_a ? -a_reg : a_reg;
  assign mag_b      = sign_b ? -b_reg : b_reg;
  assign mag_b_safe = (b_reg == '0) ? WIDTH'(1) : mag_b;
  assign b_safe     = (b_reg == '0) ? WIDTH'(1) : b_reg;
  assign sq         = mag_a / mag_b_safe;
  assign sr         = mag_a % mag_b_safe;
  assign quo_s      = (sign_a ^ sign_b) ? -sq : sq;
  assign rem_s      = sign_a ? -sr : sr;
  assign uq         = a_reg / b_safe;
  assign ur         = a_reg % b_safe;

  always_comb begin
    res = acc;
    case (op_reg)
      3'd0: res = prod_s;
      3'd1: res = prod_u;
      3'd2: if (b_reg != '0) res = {rem_s, quo_s};
      3'd3: if (b_reg != '0) res = {ur, uq};
`ifdef MD_UNIT_MACC_EN
      3'd4: res = acc + prod_s;
      3'd5: res = acc + prod_u;
      3'd6: res = acc - prod_s;
      3'd7: res = acc - prod_u;
`endif
      default: res = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = op_div ? DIV : MUL;
      MUL,
      DIV:     if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = done_reg;
    hi   = hi_reg;
    lo   = lo_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= commit;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        op_reg  <= md_op;
        cnt_reg <= op_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (state_reg != IDLE) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
      if (commit) begin
        {hi_reg, lo_reg} <= res;
      end else if (mt_ok) begin
        if (hi_we) hi_reg <= a;
        if (lo_we) lo_reg <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: stimulus pushes expected {hi,lo}, a monitor checks on each done pulse.
module tb_md_unit_param;
  logic        clk = 1'b0;
  logic        reset, req, start, hi_we, lo_we;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  md_unit_param dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=no_done", {hi, lo});
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Caller is at a negedge. we_cyc==0 raises hi_we/lo_we together with start.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input int n, input int req_cyc, input int we_cyc);
    int i;
    md_op = op; a = av; b = bv; start = 1'b1;
    hi_we = (we_cyc == 0); lo_we = (we_cyc == 0);
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    i = 0;
    while (busy === 1'b1 && i < 200) begin
      i++;
      req   = (i == req_cyc);
      hi_we = (i == we_cyc);
      a     = (i == we_cyc) ? 32'h55 : $urandom;
      b     = $urandom;
      @(negedge clk);
    end
    req = 1'b0; hi_we = 1'b0;
    check("busy_cycles", 64'(i), 64'(n));
    check("done_pulse", {63'd0, done}, 64'd1);
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
    a = v; hi_we = wh; lo_we = wl;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    md_op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

    // Consecutive run_op calls launch in the done cycle of the previous op.
    run_op(3'd0, 32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA, 5, 99, 99);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 10, 99, 99);
    run_op(3'd3, 32'd7,        32'd0,        64'hFFFFFFFF_FFFFFFFD, 10, 99, 99);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 99, 99);
    run_op(3'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 10, 99, 99);
    run_op(3'd2, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, 99, 99);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5, 99, 99);

    // req blocks a launch.
    md_op = 3'd1; a = 32'h10000; b = 32'h10000; start = 1'b1; req = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0;
    check("req_blocks_start", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("req_no_busy", {62'd0, busy, done}, 64'd0);
    check("req_hilo_kept", {hi, lo}, 64'hFFFFFFFE_00000001);

    // req during busy does not cancel; mthi during busy is ignored.
    run_op(3'd1, 32'h10000, 32'h10000, 64'h00000001_00000000, 5, 3, 99);
    run_op(3'd0, 32'd3,     32'd4,     64'h00000000_0000000C, 5, 99, 2);

    mt(1'b1, 1'b1, 32'h55);
    check("mthi_mtlo_both", {hi, lo}, 64'h00000055_00000055);

    // start with writes in IDLE: start wins (DIVU by zero keeps HI/LO).
    run_op(3'd3, 32'd9, 32'd0, 64'h00000055_00000055, 10, 99, 0);

    // Reset aborts an in-flight divide with no commit.
    md_op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_abort", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    check("reset_no_commit", {62'd0, busy, done}, 64'd0);

    mt(1'b1, 1'b0, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFFFFFF);
    check("macc_preload", {hi, lo}, 64'h00000000_FFFFFFFF);
`ifdef MD_UNIT_MACC_EN
    run_op(3'd5, 32'd1, 32'd1, 64'h00000001_00000000, 5, 99, 99);
    run_op(3'd6, 32'd2, 32'd1, 64'h00000000_FFFFFFFE, 5, 99, 99);
`else
    md_op = 3'd5; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("macc_disabled_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("macc_disabled_idle", {62'd0, busy, done}, 64'd0);
    check("macc_disabled_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
